// File: rtl/pa_idu_gpr_wb_ctrl.sv
// GPR write-back port controller: ALU/DIV arbitration onto port 0, LSU and late-load
// ports 1/2, rd decode to per-GPR enables, one-cycle output registers, DIV starvation stall.
module pa_idu_gpr_wb_ctrl #(
  parameter int STALL_LIMIT = 3
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        ifu_idu_warm_up,
  input  logic        alu_wb_vld,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  input  logic        div_wb_vld,
  input  logic [4:0]  div_wb_rd,
  input  logic [31:0] div_wb_data,
  output logic        div_wb_ack,
  input  logic        lsu_wb_vld,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  input  logic        lsu_late_vld,
  input  logic [4:0]  lsu_late_rd,
  input  logic [31:0] lsu_late_data,
  output logic [31:1] reg_write_en0_x,
  output logic [31:1] reg_write_en1_x,
  output logic [31:1] reg_write_en2_x,
  output logic [31:1] reg_fwd_en0_x,
  output logic [31:1] reg_fwd_en1_x,
  output logic [31:1] reg_fwd_en2_x,
  output logic [31:0] write_data0,
  output logic [31:0] write_data1,
  output logic [31:0] write_data2,
  output logic        idu_alu_wb_stall
);

  localparam logic [2:0] LIMIT = 3'(STALL_LIMIT);

  // x0 is hardwired, so rd = 0 decodes to no enable at all
  function automatic logic [31:1] rd_dec(input logic vld, input logic [4:0] rd);
    logic [31:0] oh;
    oh = 32'd1 << rd;
    return vld ? oh[31:1] : 31'd0;
  endfunction

  logic [31:1] en0_d, en0_q, en1_d, en1_q, en2_d, en2_q;
  logic [31:0] data0_d, data0_q, data1_d, data1_q, data2_d, data2_q;
  logic [2:0]  cnt_d, cnt_q;
  logic        stall_d, stall_q;
  logic        p0_vld;
  logic [4:0]  p0_rd;
  logic [31:0] p0_data;

  always_comb begin
    div_wb_ack = div_wb_vld & ~alu_wb_vld & ~ifu_idu_warm_up;
    p0_vld     = alu_wb_vld | div_wb_ack;
    p0_rd      = alu_wb_vld ? alu_wb_rd   : div_wb_rd;
    p0_data    = alu_wb_vld ? alu_wb_data : div_wb_data;

    if (ifu_idu_warm_up) begin
      en0_d   = '1;
      data0_d = '0;
    end else begin
      en0_d   = rd_dec(p0_vld, p0_rd);
      data0_d = (|en0_d) ? p0_data : data0_q;
    end
    en1_d   = rd_dec(lsu_wb_vld, lsu_wb_rd);
    data1_d = (|en1_d) ? lsu_wb_data : data1_q;
    en2_d   = rd_dec(lsu_late_vld, lsu_late_rd);
    data2_d = (|en2_d) ? lsu_late_data : data2_q;

    // counts cycles a waiting DIV result loses port 0 to the ALU
    if (div_wb_ack | ~div_wb_vld)
      cnt_d = '0;
    else if (alu_wb_vld && cnt_q != 3'd7)
      cnt_d = cnt_q + 3'd1;
    else
      cnt_d = cnt_q;

    if (div_wb_ack)
      stall_d = 1'b0;
    else if (cnt_d >= LIMIT)
      stall_d = 1'b1;
    else
      stall_d = stall_q;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      en0_q   <= '0;
      en1_q   <= '0;
      en2_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      en0_q   <= en0_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign reg_write_en0_x  = en0_q;
  assign reg_write_en1_x  = en1_q;
  assign reg_write_en2_x  = en2_q;
  assign reg_fwd_en0_x    = en0_q;
  assign reg_fwd_en1_x    = en1_q;
  assign reg_fwd_en2_x    = en2_q;
  assign write_data0      = data0_q;
  assign write_data1      = data1_q;
  assign write_data2      = data2_q;
  assign idu_alu_wb_stall = stall_q;

endmodule
